// File: rtl/elevator_pkg.sv
// Shared elevator queue definitions: entry/tail widths, types and index helpers.
package elevator_pkg;

    localparam int unsigned LVL_W  = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned TAIL_W = 3;

    typedef logic [LVL_W-1:0]  lvl_t;
    typedef logic [TAIL_W-1:0] tail_t;

    // Queue entry index helpers: entry 0 is the head, LAST_IDX the far end.
    localparam int unsigned HEAD_IDX = 0;
    localparam int unsigned LAST_IDX = DEPTH - 1;

endpackage

// File: rtl/lvl_queue_match.sv
// Duplicate detector: flags a request floor that already sits in a valid
// slot of the (post-shift) queue. Used only when LVL_QUEUE_DEDUP_EN is defined.
module lvl_queue_match
    import elevator_pkg::*;
(
    input  logic [DEPTH*LVL_W-1:0] entries_flat,
    input  logic [TAIL_W-1:0]      valid_cnt,
    input  logic [LVL_W-1:0]       req_lvl,
    output logic                   hit
);

    // Compare against valid slots only; slots at or beyond the tail hold 0.
    always_comb begin
        hit = 1'b0;
        for (int unsigned i = HEAD_IDX; i < DEPTH; i++) begin
            if ((tail_t'(i) < valid_cnt) &&
                (lvl_t'(entries_flat[i*LVL_W +: LVL_W]) == req_lvl)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lvl_queue_enq.sv
// Elevator request queue, enqueue side. Requests enter through a valid/ready
// handshake and are appended at the tail; the removal logic pops the head
// with shift. Optional duplicate suppression: define LVL_QUEUE_DEDUP_EN.
module lvl_queue_enq
    import elevator_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [LVL_W-1:0]       req_lvl,
    output logic                   req_ready,
    input  logic                   shift,
    output logic [DEPTH*LVL_W-1:0] queue_flat,
    output logic [TAIL_W-1:0]      tail,
    output logic                   empty,
    output logic                   full,
    output logic                   dup_drop
);

    lvl_t  q    [DEPTH];
    lvl_t  ps_q [DEPTH];
    tail_t ps_tail;
    logic  shift_eff;
    logic  accept;
    logic  hit;
    logic  store;

    assign empty     = (tail == '0);
    assign full      = (tail == tail_t'(DEPTH));
    assign req_ready = !full || shift;
    assign shift_eff = shift && !empty;
    assign accept    = req_valid && req_ready;
    assign ps_tail   = tail - tail_t'(shift_eff);
    assign store     = accept && !hit;

    // Queue contents after this cycle's pop, before any store.
    always_comb begin
        for (int unsigned i = HEAD_IDX; i < DEPTH; i++) begin
            ps_q[i] = q[i];
        end
        if (shift_eff) begin
            for (int unsigned i = HEAD_IDX; i < LAST_IDX; i++) begin
                ps_q[i] = q[i+1];
            end
            ps_q[LAST_IDX] = '0;
        end
    end

    // Flatten the registered entries, head in the low bits.
    always_comb begin
        queue_flat = '0;
        for (int unsigned i = HEAD_IDX; i < DEPTH; i++) begin
            queue_flat[i*LVL_W +: LVL_W] = q[i];
        end
    end

    // Apply pop then append at the post-shift tail; accept while full only
    // happens with a pop, so ps_tail never exceeds LAST_IDX on a store.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = HEAD_IDX; i < DEPTH; i++) begin
                q[i] <= '0;
            end
            tail <= '0;
        end else begin
            for (int unsigned i = HEAD_IDX; i < DEPTH; i++) begin
                if (store && (ps_tail == tail_t'(i))) begin
                    q[i] <= req_lvl;
                end else begin
                    q[i] <= ps_q[i];
                end
            end
            tail <= ps_tail + tail_t'(store);
        end
    end

`ifdef LVL_QUEUE_DEDUP_EN
    logic [DEPTH*LVL_W-1:0] ps_flat;

    // Flatten the post-shift entries so a popped head never counts as a match.
    always_comb begin
        ps_flat = '0;
        for (int unsigned i = HEAD_IDX; i < DEPTH; i++) begin
            ps_flat[i*LVL_W +: LVL_W] = ps_q[i];
        end
    end

    lvl_queue_match u_match (
        .entries_flat (ps_flat),
        .valid_cnt    (ps_tail),
        .req_lvl      (req_lvl),
        .hit          (hit)
    );

    // One-cycle pulse when an accepted request was dropped as a duplicate.
    always_ff @(posedge clk) begin
        if (rst) begin
            dup_drop <= 1'b0;
        end else begin
            dup_drop <= accept && hit;
        end
    end
`else
    assign hit      = 1'b0;
    assign dup_drop = 1'b0;
`endif

endmodule

// File: doc/lvl_queue_enq.md
Name: lvl_queue_enq

Overview:
- Registered elevator request queue with the enqueue (add) side owned here.
- Accepts floor requests from the call-button front end through a valid/ready handshake and appends them at the tail.
- Exposes the queue contents and tail count to the per-level removal logic.
- Takes back a head-pop (shift) strobe from that removal logic and compacts the queue.

Parameters:
- LVL_W, 2, bits per floor entry (4 floors).
- DEPTH, 4, number of queue entries.
- TAIL_W, 3, tail count width; holds 0..DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_lvl  in  LVL_W  requested floor.
- req_ready  out  1  block can accept this cycle.
- shift  in  1  pop head entry (from removal logic).
- queue_flat  out  DEPTH*LVL_W  entries; entry i at bits [i*LVL_W +: LVL_W], entry 0 = head.
- tail  out  TAIL_W  number of valid entries.
- empty  out  1  tail == 0.
- full  out  1  tail == DEPTH.
- dup_drop  out  1  one-cycle pulse: last accepted request was a duplicate and was not stored.

Behaviour:
- Reset (rst=1 at a clk edge): all entries 2'b00, tail=0, dup_drop=0. Then empty=1, full=0, req_ready=1.
- rst has priority over shift and req in the same cycle; a request offered during reset is not accepted.
- req_ready = !full || shift. This is combinational from shift; there is no combinational path from req_valid.
- accept = req_valid && req_ready.
- Shift, effective only when tail != 0:
  - next entry[i] = entry[i+1] for i < DEPTH-1.
  - next entry[DEPTH-1] = 0.
  - tail decrements by 1.
- Shift with tail == 0 is ignored; no state change.
- Store on accept (non-duplicate): the request is written at index tail (no shift) or tail-1 (shift effective); tail increments.
- Shift and store in the same cycle: net tail unchanged; the new entry lands at the post-shift tail.
- Full + shift + accept: legal. The head is popped and the request is stored at DEPTH-1; tail stays DEPTH.
- Entries at index >= tail are always 0 (cleared on pop, never left stale).
- Latency: an accepted request is visible in queue_flat and tail on the next clk edge. dup_drop rises on that same edge for exactly one cycle.
- Write enable and the tail increment must compute in TAIL_W bits; no wrap past DEPTH is possible, because accept while full requires shift.

Optional Feature:
- Macro: LVL_QUEUE_DEDUP_EN.
- Defined:
  - An accepted req_lvl equal to any valid entry after this cycle's shift is completed (handshake succeeds) but not stored.
  - Tail is unchanged by that request, and dup_drop pulses.
  - A request equal to the head being popped in the same cycle is not a duplicate and is stored.
- Undefined:
  - Every accepted request is stored; duplicates occupy separate entries.
  - dup_drop is tied to 0.

Decomposition:
- Shared package elevator_pkg:
  - LVL_W, DEPTH, TAIL_W.
  - typedef lvl_t (LVL_W bits).
  - typedef tail_t (TAIL_W bits).
  - Queue entry index helper constants.
- One sub-module: lvl_queue_match.
  - Combinational.
  - Inputs: post-shift entries, post-shift tail, req_lvl.
  - Output: hit flag.
  - Instantiated only under LVL_QUEUE_DEDUP_EN.

Test Plan:
1. Reset, then enqueue floors 3,2,1 on consecutive cycles:
   - tail=3, queue_flat=8'b00_01_10_11, empty=0, full=0.
2. Fill to 4 entries (3,2,1,0), then assert req_valid with req_lvl=2, shift=0:
   - full=1, req_ready=0, no state change.
   - Then set shift=1: req_ready=1; next cycle queue = 2,1,0,2 head-first, tail=4.
3. Queue 3,1 (tail=2); same cycle shift=1 and req_lvl=2 accepted:
   - next queue = 1,2, tail=2, entries 2..3 = 0.
4. Empty queue, shift=1 for 3 cycles:
   - tail stays 0, queue_flat=0, empty=1.
5. With LVL_QUEUE_DEDUP_EN, queue 1,3; request 3:
   - accepted, tail stays 2, dup_drop=1 for one cycle.
   - Request 1 with shift=1: stored, queue = 3,1.
   - Without the macro, request 3 gives 1,3,3, tail=3, dup_drop=0.
6. Queue 2,1,3 (tail=3); assert rst together with req_valid and shift:
   - next cycle tail=0, queue_flat=0, dup_drop=0, req_ready=1.
